// File: rtl/gsim_seq_ctrl_if.sv
// Handshake/control bundle between the GSIM host side and the shreg sequencing controller.
interface gsim_seq_ctrl_if #(
    parameter int unsigned ITER_W = 6
);
    logic              start;
    logic [ITER_W-1:0] iter_num;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        sh_ctrl;
    logic              sh_en;
    logic              pe_stall;
    logic              row_valid;
    logic [3:0]        row_idx;
    logic              out_valid;
    logic [3:0]        out_idx;
    logic              out_ready;
    logic              busy;
    logic              done;

    modport master (
        output start, iter_num, in_valid, pe_stall, out_ready,
        input  in_ready, sh_ctrl, sh_en, row_valid, row_idx,
               out_valid, out_idx, busy, done
    );

    modport slave (
        input  start, iter_num, in_valid, pe_stall, out_ready,
        output in_ready, sh_ctrl, sh_en, row_valid, row_idx,
               out_valid, out_idx, busy, done
    );
endinterface

// File: rtl/gsim_seq_ctrl.sv
// Sequencing controller for the GSIM shreg operand file: b-vector load, N sweeps, solution readout.
module gsim_seq_ctrl #(
    parameter int unsigned ITER_W = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    gsim_seq_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ITER,
        S_OUT,
        S_DONE
    } state_t;

    state_t            state, state_nx;
    logic [3:0]        cnt, cnt_nx;
    logic [ITER_W-1:0] it, it_nx;
    logic [ITER_W-1:0] n_r, n_r_nx;

    logic       in_ready, sh_en, row_valid, out_valid, busy, done;
    logic [1:0] sh_ctrl;
    logic [3:0] row_idx, out_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            it    <= '0;
            n_r   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            it    <= it_nx;
            n_r   <= n_r_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        it_nx     = it;
        n_r_nx    = n_r;
        in_ready  = 1'b0;
        sh_ctrl   = 2'b00;
        sh_en     = 1'b0;
        row_valid = 1'b0;
        row_idx   = '0;
        out_valid = 1'b0;
        out_idx   = '0;
        busy      = 1'b0;
        done      = 1'b0;

        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    n_r_nx   = bus.iter_num;
                    cnt_nx   = '0;
                    it_nx    = '0;
                    state_nx = S_LOAD;
                end
            end
            S_LOAD: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    sh_en  = 1'b1;
                    cnt_nx = cnt + 4'd1;
                    if (cnt == 4'd15)
                        state_nx = (n_r != '0) ? S_ITER : S_OUT;
                end
            end
            S_ITER: begin
                busy    = 1'b1;
                row_idx = cnt;
                // A stall freezes everything, including the sweep count on row 15.
                if (!bus.pe_stall) begin
                    row_valid = 1'b1;
                    sh_ctrl   = 2'b01;
                    sh_en     = 1'b1;
                    cnt_nx    = cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        it_nx = it + ITER_W'(1);
                        if (it == n_r - ITER_W'(1))
                            state_nx = S_OUT;
                    end
                end
            end
            S_OUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_idx   = cnt;
                if (bus.out_ready) begin
                    sh_ctrl = 2'b01;
                    cnt_nx  = cnt + 4'd1;
                    if (cnt == 4'd15)
                        state_nx = S_DONE;
                end
            end
            S_DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign bus.in_ready  = in_ready;
    assign bus.sh_ctrl   = sh_ctrl;
    assign bus.sh_en     = sh_en;
    assign bus.row_valid = row_valid;
    assign bus.row_idx   = row_idx;
    assign bus.out_valid = out_valid;
    assign bus.out_idx   = out_idx;
    assign bus.busy      = busy;
    assign bus.done      = done;
endmodule

// File: tb/tb_gsim_seq_ctrl.sv
// Directed bench for gsim_seq_ctrl: full solves with and without backpressure, stalls, reset.
module tb_gsim_seq_ctrl;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    gsim_seq_ctrl_if #(.ITER_W(6)) bus ();

    gsim_seq_ctrl #(.ITER_W(6)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] out_vec();
        return {bus.in_ready, bus.sh_ctrl, bus.sh_en, bus.row_valid, bus.row_idx,
                bus.out_valid, bus.out_idx, bus.busy, bus.done};
    endfunction

    // Runs one solve from a start pulse; inputs are driven 1ns after each rising
    // edge and outputs sampled on the falling edge. k counts cycles after start.
    task automatic run_solve(input int n, input bit in_alt, input int stall_n,
                             input int pause_n, input int start_at,
                             output int done_k, output int load_len, output int n_load,
                             output int n_rows, output int n_outs, output int n_stall,
                             output int n_bad, output int busy_after);
        int stall_left;
        int pause_left;
        bit in_iter;
        logic [5:0] nv;
        stall_left = stall_n;
        pause_left = pause_n;
        done_k = -1; load_len = 0; n_load = 0; n_rows = 0; n_outs = 0;
        n_stall = 0; n_bad = 0; busy_after = -1;
        nv = n[5:0];
        @(posedge clk); #1;
        bus.start = 1'b1; bus.iter_num = nv;
        bus.in_valid = 1'b0; bus.pe_stall = 1'b0; bus.out_ready = 1'b1;
        for (int k = 1; k <= 3000 && done_k < 0; k++) begin
            @(posedge clk); #1;
            bus.start = (k == start_at);
            if (k == start_at) bus.iter_num = 6'd5;
            bus.in_valid = in_alt ? (k % 2 == 0) : 1'b1;
            in_iter = bus.busy && !bus.in_ready && !bus.out_valid && !bus.done;
            bus.pe_stall = in_iter && (bus.row_idx == 4'd15) && (stall_left > 0);
            if (bus.pe_stall) stall_left--;
            bus.out_ready = !(bus.out_valid && (bus.out_idx == 4'd7) && (pause_left > 0));
            if (!bus.out_ready) pause_left--;
            @(negedge clk);
            if (bus.sh_ctrl[1]) n_bad++;
            if (bus.in_ready) begin
                load_len++;
                if (bus.in_valid) begin
                    n_load++;
                    if ({bus.sh_ctrl, bus.sh_en} != 3'b001) n_bad++;
                end else if ({bus.sh_ctrl, bus.sh_en} != 3'b000) n_bad++;
            end
            if (in_iter) begin
                if (bus.pe_stall) begin
                    n_stall++;
                    if (bus.row_valid || {bus.sh_ctrl, bus.sh_en} != 3'b000) n_bad++;
                end else begin
                    if (!bus.row_valid || bus.row_idx != 4'(n_rows % 16) ||
                        {bus.sh_ctrl, bus.sh_en} != 3'b011) n_bad++;
                    n_rows++;
                end
            end
            if (bus.out_valid) begin
                if (bus.out_idx != 4'(n_outs)) n_bad++;
                if (bus.out_ready) begin
                    if ({bus.sh_ctrl, bus.sh_en} != 3'b010) n_bad++;
                    n_outs++;
                end else if ({bus.sh_ctrl, bus.sh_en} != 3'b000) n_bad++;
            end
            if (bus.done) done_k = k;
        end
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.pe_stall = 1'b0; bus.out_ready = 1'b0;
        if (done_k > 0) begin
            @(posedge clk); #1;
            @(negedge clk);
            busy_after = int'(bus.busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0; bus.iter_num = '0; bus.in_valid = 1'b0;
        bus.pe_stall = 1'b0; bus.out_ready = 1'b0;
        #2;
        tests++;
        if (out_vec() !== 16'h0000) begin
            fails++; $display("FAIL reset_outputs: got %h expected 0000", out_vec());
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (out_vec() !== 16'h0000) begin
            fails++; $display("FAIL idle_outputs: got %h expected 0000", out_vec());
        end
    endtask

    task automatic check_solve(input string nm, input int n, input bit in_alt, input int stall_n,
                               input int pause_n, input int start_at, input int exp_done,
                               input int exp_load_len, input int exp_rows, input int exp_stall);
        int dk, ll, nl, nr, no, ns, nb, ba;
        run_solve(n, in_alt, stall_n, pause_n, start_at, dk, ll, nl, nr, no, ns, nb, ba);
        tests++;
        if (dk !== exp_done) begin fails++; $display("FAIL %s done_cycle: got %0d expected %0d", nm, dk, exp_done); end
        tests++;
        if (ll !== exp_load_len) begin fails++; $display("FAIL %s load_len: got %0d expected %0d", nm, ll, exp_load_len); end
        tests++;
        if (nl !== 16) begin fails++; $display("FAIL %s load_words: got %0d expected 16", nm, nl); end
        tests++;
        if (nr !== exp_rows) begin fails++; $display("FAIL %s rows: got %0d expected %0d", nm, nr, exp_rows); end
        tests++;
        if (no !== 16) begin fails++; $display("FAIL %s outs: got %0d expected 16", nm, no); end
        tests++;
        if (ns !== exp_stall) begin fails++; $display("FAIL %s stall_cycles: got %0d expected %0d", nm, ns, exp_stall); end
        tests++;
        if (nb !== 0) begin fails++; $display("FAIL %s ctrl_seq_errors: got %0d expected 0", nm, nb); end
        tests++;
        if (ba !== 0) begin fails++; $display("FAIL %s busy_after_done: got %0d expected 0", nm, ba); end
    endtask

    task automatic test_solve_n1();
        check_solve("n1", 1, 1'b0, 0, 0, 0, 49, 16, 16, 0);
    endtask

    task automatic test_solve_n3();
        check_solve("n3", 3, 1'b0, 0, 0, 0, 81, 16, 48, 0);
    endtask

    task automatic test_solve_n0();
        check_solve("n0", 0, 1'b0, 0, 0, 0, 33, 16, 0, 0);
    endtask

    task automatic test_in_backpressure();
        check_solve("in_alt", 1, 1'b1, 0, 0, 0, 65, 32, 16, 0);
    endtask

    task automatic test_pe_stall();
        check_solve("stall15", 2, 1'b0, 3, 0, 0, 68, 16, 32, 3);
    endtask

    task automatic test_out_backpressure();
        check_solve("out_pause", 1, 1'b0, 0, 5, 0, 54, 16, 16, 0);
    endtask

    task automatic test_start_ignored();
        check_solve("start_in_iter", 1, 1'b0, 0, 0, 20, 49, 16, 16, 0);
    endtask

    task automatic test_reset_mid_iter();
        @(posedge clk); #1;
        bus.start = 1'b1; bus.iter_num = 6'd2;
        bus.in_valid = 1'b1; bus.pe_stall = 1'b0; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (24) @(posedge clk);
        #3;
        tests++;
        if (bus.row_valid !== 1'b1 || bus.busy !== 1'b1) begin
            fails++; $display("FAIL pre_reset_in_iter: got rv=%b busy=%b expected 1 1", bus.row_valid, bus.busy);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (out_vec() !== 16'h0000) begin
            fails++; $display("FAIL async_reset_mid_iter: got %h expected 0000", out_vec());
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_solve("after_reset", 1, 1'b0, 0, 0, 0, 49, 16, 16, 0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_solve_n1();
        test_solve_n3();
        test_solve_n0();
        test_in_backpressure();
        test_pe_stall();
        test_out_backpressure();
        test_start_ignored();
        test_reset_mid_iter();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
